// File: rtl/sram_pkg.sv
// Shared constants for the asynchronous SRAM front end: state encoding,
// default wait-state counts and the SRAM data width.
package sram_pkg;

  localparam int DW          = 16;
  localparam int RD_WAIT_DEF = 4;
  localparam int WR_WAIT_DEF = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RD     = 3'd1;
  localparam logic [2:0] ST_RD_END = 3'd2;
  localparam logic [2:0] ST_WR     = 3'd3;
  localparam logic [2:0] ST_WR_END = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    RD     = ST_RD,
    RD_END = ST_RD_END,
    WR     = ST_WR,
    WR_END = ST_WR_END
  } state_t;

endpackage

// File: rtl/sram_async_ctrl.sv
// Single-request front end for an asynchronous 16-bit SRAM: sequences CE/OE/WE
// with fixed wait states and owns the bidirectional data bus.
module sram_async_ctrl
  import sram_pkg::*;
#(
  parameter int RD_WAIT = RD_WAIT_DEF,
  parameter int WR_WAIT = WR_WAIT_DEF,
  parameter int AW      = 18
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          rw,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic [1:0]    be,
  output logic          ready,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic [AW-1:0] sram_adr,
  inout  wire  [DW-1:0] sram_dat,
  output logic          sram_we_n,
  output logic          sram_oe_n,
  output logic          sram_ce_n,
  output logic          sram_ub,
  output logic          sram_lb
);

  localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_WAIT - 1);

  state_t        state, state_d;
  logic [3:0]    wcnt, wcnt_d;
  logic          ready_d, rvalid_d;
  logic [DW-1:0] rdata_d, wdata_q, wdata_d;
  logic [AW-1:0] adr_d;
  logic          dat_oe, dat_oe_d;
  logic          we_n_d, oe_n_d, ce_n_d, ub_d, lb_d;

  // Bus is driven only from the registered enable, so it can never glitch on.
  assign sram_dat = dat_oe ? wdata_q : {DW{1'bz}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wcnt      <= '0;
      ready     <= 1'b1;
      rvalid    <= 1'b0;
      rdata     <= '0;
      wdata_q   <= '0;
      sram_adr  <= '0;
      dat_oe    <= 1'b0;
      sram_we_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_ce_n <= 1'b1;
      sram_ub   <= 1'b1;
      sram_lb   <= 1'b1;
    end else begin
      state     <= state_d;
      wcnt      <= wcnt_d;
      ready     <= ready_d;
      rvalid    <= rvalid_d;
      rdata     <= rdata_d;
      wdata_q   <= wdata_d;
      sram_adr  <= adr_d;
      dat_oe    <= dat_oe_d;
      sram_we_n <= we_n_d;
      sram_oe_n <= oe_n_d;
      sram_ce_n <= ce_n_d;
      sram_ub   <= ub_d;
      sram_lb   <= lb_d;
    end
  end

  always_comb begin
    state_d  = state;
    wcnt_d   = wcnt;
    ready_d  = ready;
    rvalid_d = rvalid;
    rdata_d  = rdata;
    wdata_d  = wdata_q;
    adr_d    = sram_adr;
    dat_oe_d = dat_oe;
    we_n_d   = sram_we_n;
    oe_n_d   = sram_oe_n;
    ce_n_d   = sram_ce_n;
    ub_d     = sram_ub;
    lb_d     = sram_lb;
    case (state)
      IDLE: begin
        if (req) begin
          adr_d   = addr;
          wdata_d = wdata;
          ub_d    = ~be[1];
          lb_d    = ~be[0];
          ready_d = 1'b0;
          ce_n_d  = 1'b0;
          if (rw) begin
            state_d = RD;
            wcnt_d  = RD_LOAD;
            oe_n_d  = 1'b0;
          end else begin
            state_d  = WR;
            wcnt_d   = WR_LOAD;
            we_n_d   = 1'b0;
            dat_oe_d = 1'b1;
          end
        end
      end
      RD: begin
        wcnt_d = wcnt - 4'd1;
        if (wcnt == 4'd0) begin
          rdata_d  = sram_dat;
          rvalid_d = 1'b1;
          oe_n_d   = 1'b1;
          ce_n_d   = 1'b1;
          ub_d     = 1'b1;
          lb_d     = 1'b1;
          state_d  = RD_END;
        end
      end
      RD_END: begin
        rvalid_d = 1'b0;
        ready_d  = 1'b1;
        state_d  = IDLE;
      end
      WR: begin
        wcnt_d = wcnt - 4'd1;
        if (wcnt == 4'd0) begin
          we_n_d  = 1'b1;
          state_d = WR_END;
        end
      end
      WR_END: begin
        // CE and data held one extra cycle past WE rising for hold time.
        ce_n_d   = 1'b1;
        dat_oe_d = 1'b0;
        ub_d     = 1'b1;
        lb_d     = 1'b1;
        ready_d  = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d  = IDLE;
        ready_d  = 1'b1;
        rvalid_d = 1'b0;
        dat_oe_d = 1'b0;
        we_n_d   = 1'b1;
        oe_n_d   = 1'b1;
        ce_n_d   = 1'b1;
        ub_d     = 1'b1;
        lb_d     = 1'b1;
      end
    endcase
  end

endmodule
